alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (legal 4..32).
REQ-002 SHALL have parameter CONST_W, default 2, width of the signed immediate (legal 1..WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both 1 at a rising edge.
REQ-007 SHALL have port opcode  input  4  operation select.
REQ-008 SHALL have ports alu_rs1 and alu_rs2  input  WIDTH  operands.
REQ-009 SHALL have port constant  input  CONST_W  signed immediate for ADDI.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  result consumed when out_valid and out_ready are both 1 at a rising edge.
REQ-012 SHALL have port aluOut  output  WIDTH  registered result.
REQ-013 SHALL have port overflow  output  1  registered flag paired with aluOut.
REQ-014 SHALL have port busy  output  1  high while a multi-cycle MUL is in progress.

Function
REQ-015 Opcodes SHALL be: 0 ADD, 1 ADDI, 2 SUB, 3 SHL, 4 LT, 5 EQ0, 6 CMP4, 7 XOR, 8 AND, 9 OR, A NOT, B MUL, C SHR; D-F SHALL return aluOut=0 with overflow=0.
REQ-016 ADD: rs1+rs2 mod 2^WIDTH; overflow=carry-out.
REQ-017 ADDI: rs1+sign-extended constant mod 2^WIDTH; overflow=carry-out of the WIDTH-bit unsigned addition.
REQ-018 SUB: rs1-rs2 mod 2^WIDTH; overflow=borrow (rs1<rs2 unsigned).
REQ-019 SHL/SHR: shift rs1 by 1 logically; overflow=bit shifted out.
REQ-020 LT: 1 if rs1<rs2 as signed two's complement, else 0, zero-extended.
REQ-021 EQ0: 1 if rs1==0; CMP4: 1 if rs1[WIDTH-1:WIDTH-4]==rs2[WIDTH-1:WIDTH-4]; both zero-extended.
REQ-022 XOR/AND/OR/NOT: bitwise; NOT uses rs1 only; overflow=0 for opcodes 4-A.
REQ-023 MUL: unsigned shift-add, one bit per cycle; aluOut=low WIDTH bits; overflow=1 iff high WIDTH bits nonzero.
REQ-024 FSM states SHALL be IDLE, MUL, DONE.
REQ-025 IDLE: in_ready=1; accepted non-MUL op -> DONE next edge with result registered (latency 1); accepted MUL -> MUL.
REQ-026 MUL: in_ready=0, busy=1; exactly WIDTH cycles, then DONE (latency WIDTH+1 from accept).
REQ-027 DONE: out_valid=1; aluOut/overflow SHALL hold stable until handshake.
REQ-028 DONE with out_ready=1: in_ready=1; a simultaneous accepted request SHALL be processed back-to-back (non-MUL -> DONE with new result, MUL -> MUL); with no request -> IDLE.
REQ-029 DONE with out_ready=0: in_ready=0; inputs ignored.
REQ-030 Operands SHALL be captured at accept; later input changes SHALL not affect an in-flight result.

Reset
REQ-031 rst_n low SHALL immediately force state=IDLE, out_valid=0, busy=0, aluOut=0, overflow=0, multiplier counter/accumulator=0.
REQ-032 Reset mid-MUL or in DONE SHALL discard the pending result; first accept is possible on the first edge after rst_n rises.

Configuration
REQ-033 Macro ALU_SEQ_MUL_EN: defined -> MUL per REQ-023/026; undefined -> no MUL state or multiplier logic, opcode B treated as D-F (latency 1, aluOut=0, overflow=0), busy tied 0.

Structure
REQ-034 Package alu_seq_pkg SHALL hold the opcode enum and the FSM state enum.
REQ-035 Sub-module alu_seq_mul (iterative multiplier, start/done handshake) SHALL be instantiated only under ALU_SEQ_MUL_EN.

Verification (WIDTH=8, CONST_W=2)
REQ-036 ADD 0x01+0xFF, out_ready=1 -> next cycle aluOut=0x00, overflow=1, out_valid=1.
REQ-037 ADDI rs1=0x04, constant=2'b11 -> aluOut=0x03, overflow=1; constant=2'b01 -> 0x05, overflow=0.
REQ-038 SUB 0x01-0x04 -> 0xFD, overflow=1; LT 0x01 vs 0x84 -> 0x00; CMP4 0x00 vs 0x40 -> 0x00.
REQ-039 MUL 0x10*0x11 -> busy 8 cycles, then aluOut=0x10, overflow=1; without ALU_SEQ_MUL_EN -> 0x00 after 1 cycle.
REQ-040 out_ready=0 for 5 cycles after XOR 0x07^0x06 -> aluOut=0x01 held, in_ready=0; release with new AND request same edge -> next cycle 0x06.
REQ-041 rst_n pulsed low during MUL cycle 3 -> out_valid=0, busy=0 immediately; next NOT 0x00 -> 0xFF.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for alu_seq: opcode encoding and the FSM state enum.
// ALU_SEQ_MUL_EN adds the MUL state when the iterative multiplier is built.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_ADDI = 4'h1,
    OP_SUB  = 4'h2,
    OP_SHL  = 4'h3,
    OP_LT   = 4'h4,
    OP_EQ0  = 4'h5,
    OP_CMP4 = 4'h6,
    OP_XOR  = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_NOT  = 4'hA,
    OP_MUL  = 4'hB,
    OP_SHR  = 4'hC
  } opcode_e;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd2
  } state_e;
`endif

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: the first partial product is folded in
// on start, the remaining WIDTH-1 bits take one cycle each; done pulses with the final product.
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      done    <= 1'b0;
    end else if (start) begin
      product <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand   <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier  <= {1'b0, b[WIDTH-1:1]};
      cnt     <= CNT_W'(WIDTH - 1);
      done    <= 1'b0;
    end else if (cnt != '0) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      cnt    <= cnt - CNT_W'(1);
      done   <= (cnt == CNT_W'(1));
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready request and result channels.
// ALU_SEQ_MUL_EN enables the multi-cycle MUL opcode; otherwise MUL returns zero in one cycle.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CONST_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   alu_rs1,
  input  logic [WIDTH-1:0]   alu_rs2,
  input  logic [CONST_W-1:0] constant,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   aluOut,
  output logic               overflow,
  output logic               busy,
  output logic [1:0]         state_dbg
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // once out_valid rises, aluOut/overflow stay stable until the result transfer.
  state_e           state;
  logic             accept;
  logic [WIDTH-1:0] imm;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign imm       = WIDTH'($signed(constant));
  assign state_dbg = state;

  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (opcode)
      OP_ADD:  begin
        wide    = {1'b0, alu_rs1} + {1'b0, alu_rs2};
        alu_res = wide[WIDTH-1:0];
        alu_ovf = wide[WIDTH];
      end
      OP_ADDI: begin
        wide    = {1'b0, alu_rs1} + {1'b0, imm};
        alu_res = wide[WIDTH-1:0];
        alu_ovf = wide[WIDTH];
      end
      OP_SUB:  begin
        // The extra top bit of the difference is the borrow.
        wide    = {1'b0, alu_rs1} - {1'b0, alu_rs2};
        alu_res = wide[WIDTH-1:0];
        alu_ovf = wide[WIDTH];
      end
      OP_SHL:  begin
        alu_res = {alu_rs1[WIDTH-2:0], 1'b0};
        alu_ovf = alu_rs1[WIDTH-1];
      end
      OP_SHR:  begin
        alu_res = {1'b0, alu_rs1[WIDTH-1:1]};
        alu_ovf = alu_rs1[0];
      end
      OP_LT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(alu_rs1) < $signed(alu_rs2))};
      OP_EQ0:  alu_res = {{(WIDTH-1){1'b0}}, (alu_rs1 == '0)};
      OP_CMP4: alu_res = {{(WIDTH-1){1'b0}}, (alu_rs1[WIDTH-1-:4] == alu_rs2[WIDTH-1-:4])};
      OP_XOR:  alu_res = alu_rs1 ^ alu_rs2;
      OP_AND:  alu_res = alu_rs1 & alu_rs2;
      OP_OR:   alu_res = alu_rs1 | alu_rs2;
      OP_NOT:  alu_res = ~alu_rs1;
      default: ;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && (opcode == OP_MUL)),
    .a       (alu_rs1),
    .b       (alu_rs2),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      aluOut    <= '0;
      overflow  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      busy      <= 1'b0;
`endif
    end else if (accept) begin
`ifdef ALU_SEQ_MUL_EN
      if (opcode == OP_MUL) begin
        state     <= S_MUL;
        busy      <= 1'b1;
        out_valid <= 1'b0;
      end else begin
`else
      begin
`endif
        state     <= S_DONE;
        out_valid <= 1'b1;
        aluOut    <= alu_res;
        overflow  <= alu_ovf;
      end
    end else begin
      case (state)
`ifdef ALU_SEQ_MUL_EN
        S_MUL: if (mul_done) begin
          state     <= S_DONE;
          busy      <= 1'b0;
          out_valid <= 1'b1;
          aluOut    <= mul_product[WIDTH-1:0];
          overflow  <= |mul_product[2*WIDTH-1:WIDTH];
        end
`endif
        S_DONE: if (out_ready) begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8, CONST_W=2); MUL expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W  = 8;
  localparam int CW = 2;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    opcode;
  logic [W-1:0]  alu_rs1, alu_rs2;
  logic [CW-1:0] constant;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  aluOut;
  logic          overflow;
  logic          busy;
  logic [1:0]    state_dbg;

  logic [W:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  bit rand_bp  = 1'b0;

  alu_seq #(.WIDTH(W), .CONST_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .constant(constant),
    .out_valid(out_valid), .out_ready(out_ready), .aluOut(aluOut),
    .overflow(overflow), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model, packed as {overflow, result}
  function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic [CW-1:0] c);
    int ia, ib, ic, sa, sb, r;
    ia = int'(a);
    ib = int'(b);
    ic = c[CW-1] ? int'(c) - (1 << CW) : int'(c);
    sa = a[W-1] ? ia - (1 << W) : ia;
    sb = b[W-1] ? ib - (1 << W) : ib;
    r  = 0;
    case (op)
      4'h0: r = ia + ib;
      4'h1: r = ia + ((ic + (1 << W)) % (1 << W));
      4'h2: r = (ia - ib + (1 << W)) + ((ia < ib) ? (1 << W) : 0);
      4'h3: r = ia * 2;
      4'h4: r = (sa < sb) ? 1 : 0;
      4'h5: r = (ia == 0) ? 1 : 0;
      4'h6: r = ((ia >> (W - 4)) == (ib >> (W - 4))) ? 1 : 0;
      4'h7: r = ia ^ ib;
      4'h8: r = ia & ib;
      4'h9: r = ia | ib;
      4'hA: r = (~ia) & ((1 << W) - 1);
      4'hB: r = MUL_EN ? (((ia * ib) % (1 << W)) + (((ia * ib) >= (1 << W)) ? (1 << W) : 0)) : 0;
      4'hC: r = (ia >> 1) + ((ia & 1) << W);
      default: r = 0;
    endcase
    // For SUB the borrow was added on top of a value already offset by 2^W
    if (op == 4'h2) r = ((ia - ib + (1 << W)) % (1 << W)) + ((ia < ib) ? (1 << W) : 0);
    return (W+1)'(r);
  endfunction

  // driver tasks
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [CW-1:0] c);
    int waited = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; opcode = op; alu_rs1 = a; alu_rs2 = b; constant = c;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    else exp_q.push_back(model(op, a, b, c));
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode   = 4'($urandom_range(0, 15));
    alu_rs1  = W'($urandom);
    alu_rs2  = W'($urandom);
    constant = CW'($urandom);
  endtask

  task automatic wait_out(input string tag, input int exp_lat, output int busy_n);
    int lat = 1;
    busy_n = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (busy) busy_n++;
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  // scoreboard: compare on every result transfer
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
      else check("scoreboard", 32'({overflow, aluOut}), 32'(exp_q.pop_front()));
    end
  end

  // random backpressure
  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int bn;
    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; alu_rs1 = '0; alu_rs2 = '0;
    constant = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_aluout",    32'(aluOut),    32'd0);
    check("reset_overflow",  32'(overflow),  32'd0);
    check("reset_state",     32'(state_dbg), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    send(OP_ADD, 8'h01, 8'hFF, 2'b00);
    wait_out("add", 1, bn);
    check("add_val", 32'(aluOut), 32'h00);
    check("add_ovf", 32'(overflow), 32'd1);

    send(OP_ADDI, 8'h04, 8'h00, 2'b11);
    wait_out("addi_neg", 1, bn);
    check("addi_neg_val", 32'(aluOut), 32'h03);
    check("addi_neg_ovf", 32'(overflow), 32'd1);
    send(OP_ADDI, 8'h04, 8'h00, 2'b01);
    wait_out("addi_pos", 1, bn);
    check("addi_pos_val", 32'(aluOut), 32'h05);
    check("addi_pos_ovf", 32'(overflow), 32'd0);

    send(OP_SUB, 8'h01, 8'h04, 2'b00);
    wait_out("sub", 1, bn);
    check("sub_val", 32'(aluOut), 32'hFD);
    check("sub_ovf", 32'(overflow), 32'd1);
    send(OP_LT, 8'h01, 8'h84, 2'b00);
    wait_out("lt", 1, bn);
    check("lt_val", 32'(aluOut), 32'h00);
    send(OP_CMP4, 8'h00, 8'h40, 2'b00);
    wait_out("cmp4", 1, bn);
    check("cmp4_val", 32'(aluOut), 32'h00);

    send(OP_MUL, 8'h10, 8'h11, 2'b00);
    wait_out("mul", MUL_EN ? W + 1 : 1, bn);
    check("mul_busy_cycles", 32'(bn), MUL_EN ? 32'(W) : 32'd0);
    check("mul_val", 32'(aluOut), MUL_EN ? 32'h10 : 32'h00);
    check("mul_ovf", 32'(overflow), MUL_EN ? 32'd1 : 32'd0);

    // backpressure hold, ignored input, then back-to-back release
    @(posedge clk); #1 out_ready = 1'b0;
    send(OP_XOR, 8'h07, 8'h06, 2'b00);
    in_valid = 1'b1; opcode = OP_OR; alu_rs1 = 8'hA5; alu_rs2 = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_val",   32'(aluOut),    32'h01);
      check("hold_ready", 32'(in_ready),  32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; opcode = OP_AND; alu_rs1 = 8'h06; alu_rs2 = 8'h07;
    @(negedge clk);
    check("release_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(model(OP_AND, 8'h06, 8'h07, 2'b00));
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_val",   32'(aluOut),    32'h06);

    // reset during a multiply
    send(OP_MUL, 8'h03, 8'h05, 2'b00);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_busy",  32'(busy),      32'd0);
    check("rst_mid_aluout", 32'(aluOut),   32'd0);
    check("rst_mid_state", 32'(state_dbg), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b1; opcode = OP_NOT; alu_rs1 = 8'h00; alu_rs2 = W'($urandom);
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(model(OP_NOT, 8'h00, alu_rs2, 2'b00));
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("not_valid", 32'(out_valid), 32'd1);
    check("not_val",   32'(aluOut),    32'hFF);
    check("not_ovf",   32'(overflow),  32'd0);

    // random traffic with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++)
      send(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), CW'($urandom));
    rand_bp = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
